mult_div_unit: RTL

- Parametrised multicycle multiply/divide unit that feeds the HI/LO registers of the multicycle CPU datapath.
- Operands come from the MDSrcA/MDSrcB mux outputs; the control unit starts an operation and waits for a done pulse before writing HI/LO.
- Generalises the fixed 32-bit MULT/DIV path to any even WIDTH.
- Adds signed and unsigned modes, a divide-by-zero flag and a busy/done handshake.

---
 rtl/mdu_pkg.sv | 15 +
 rtl/mdu_abs.sv | 12 +
 rtl/mult_div_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multicycle multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate, used both for operand magnitudes and result sign fix-up.
module mdu_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = negate ? WIDTH'(WIDTH'(0) - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide feeding HI/LO: shift-add multiply,
// restoring divide on magnitudes, then a single sign fix-up cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic             op_div_c, op_signed_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quo_fix_c, rem_fix_c;
  logic [AW-1:0]    prod_fix_c, mul_next_c, div_next_c;
  logic [WIDTH:0]   sum_c, diff_c;

  assign op_div_c    = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed_c = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg_c     = op_signed_c & src_a[WIDTH-1];
  assign b_neg_c     = op_signed_c & src_b[WIDTH-1];

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.value(src_a), .negate(a_neg_c), .result_c(a_mag_c));
  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.value(src_b), .negate(b_neg_c), .result_c(b_mag_c));

  mdu_abs #(.WIDTH(AW)) u_fix_prod (
    .value(acc_q), .negate(res_neg_q), .result_c(prod_fix_c)
  );
  mdu_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .value(acc_q[WIDTH-1:0]), .negate(res_neg_q), .result_c(quo_fix_c)
  );
  mdu_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc_q[AW-1:WIDTH]), .negate(rem_neg_q), .result_c(rem_fix_c)
  );

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  always_comb begin
    sum_c = {1'b0, acc_q[AW-1:WIDTH]};
    if (acc_q[0]) begin
      sum_c = sum_c + {1'b0, opnd_q};
    end
    mul_next_c = {sum_c, acc_q[WIDTH-1:1]};
  end

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}, shifted left each cycle.
  always_comb begin
    diff_c = acc_q[AW-1:WIDTH-1] - {1'b0, opnd_q};
    if (diff_c[WIDTH]) begin
      div_next_c = {acc_q[AW-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next_c = {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_div_c && (src_b == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            is_div_d  = op_div_c;
            res_neg_d = a_neg_c ^ b_neg_c;
            rem_neg_d = a_neg_c;
            opnd_d    = op_div_c ? b_mag_c : a_mag_c;
            acc_d     = {WIDTH'(0), (op_div_c ? a_mag_c : b_mag_c)};
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next_c : mul_next_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end else begin
          hi_d = prod_fix_c[AW-1:WIDTH];
          lo_d = prod_fix_c[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
